face_detect_mac_pipe: RTL and testbench

- Parametrised, pipelined multiply-accumulate unit for the face-detection HLS accelerator datapath.
- Generalises the fixed 16-bit-unsigned by 8-bit-signed, 4-stage multiplier:
  - configurable operand widths and signedness
  - configurable pipeline depth
  - valid tracking
  - optional running accumulation with group clear
  - saturating output with a sticky overflow flag
- Used for weighted-feature sums (pixel x weight) in the classifier stages.

---
 rtl/face_detect_mac_pipe.sv | 160 ++++++++++++++++
 tb/tb_face_detect_mac_pipe.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/face_detect_mac_pipe.sv
// Purpose: pipelined multiply-accumulate, pixel x weight with optional running sum, saturation and sticky overflow.
// Latency: NUM_STAGE ce-enabled cycles from input sample to dout/out_valid; one sample per ce-cycle.
// Backpressure: none; ce=0 freezes every register (valids included), so nothing is lost or duplicated.
module face_detect_mac_pipe #(
    parameter int DIN0_WIDTH  = 16,
    parameter int DIN0_SIGNED = 0,
    parameter int DIN1_WIDTH  = 8,
    parameter int DIN1_SIGNED = 1,
    parameter int ACC_WIDTH   = 32,
    parameter int DOUT_WIDTH  = 24,
    parameter int NUM_STAGE   = 4,
    parameter int SAT_EN      = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ce,
    input  logic                         in_valid,
    input  logic [DIN0_WIDTH-1:0]        din0,
    input  logic [DIN1_WIDTH-1:0]        din1,
    input  logic                         acc_en,
    input  logic                         acc_clr,
    output logic signed [DOUT_WIDTH-1:0] dout,
    output logic                         out_valid,
    output logic                         ovf
);

    // Product width of the one-bit-extended operands; stages 2..NUM_STAGE-1 live in r_pipe.
    localparam int PW = DIN0_WIDTH + DIN1_WIDTH + 2;
    localparam int ND = NUM_STAGE - 2;

    localparam logic [ACC_WIDTH-1:0]        L_ONE  = {{(ACC_WIDTH-1){1'b0}}, 1'b1};
    localparam logic signed [ACC_WIDTH-1:0] L_AMAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] L_AMIN = ~L_AMAX;
    localparam logic signed [ACC_WIDTH-1:0] L_DMAX = (L_ONE << (DOUT_WIDTH-1)) - L_ONE;
    localparam logic signed [ACC_WIDTH-1:0] L_DMIN = ~L_DMAX;

    typedef struct packed {
        logic                 vld;
        logic                 en;
        logic                 clr;
        logic signed [PW-1:0] prod;
    } pipe_t;

    logic [DIN0_WIDTH-1:0]        r_s1_din0;
    logic [DIN1_WIDTH-1:0]        r_s1_din1;
    logic                         r_s1_vld;
    logic                         r_s1_en;
    logic                         r_s1_clr;
    pipe_t                        r_pipe [ND];
    logic signed [ACC_WIDTH-1:0]  r_acc;
    logic signed [DOUT_WIDTH-1:0] r_dout;
    logic                         r_vld;
    logic                         r_ovf;

    logic signed [DIN0_WIDTH:0]   w_a_ext;
    logic signed [DIN1_WIDTH:0]   w_b_ext;
    logic signed [PW-1:0]         w_a_wide;
    logic signed [PW-1:0]         w_b_wide;
    logic signed [PW-1:0]         w_prod;
    pipe_t                        w_s2_nxt;
    pipe_t                        w_last;
    logic signed [ACC_WIDTH-1:0]  w_prod_acc;
    logic signed [ACC_WIDTH:0]    w_sum;
    logic                         w_sum_ovf;
    logic                         w_start;
    logic signed [ACC_WIDTH-1:0]  w_acc_nxt;
    logic                         w_acc_ovf;
    logic signed [DOUT_WIDTH-1:0] w_dout_nxt;
    logic                         w_dout_ovf;
    logic                         w_ovf_nxt;

    // Stage 1: capture operands and per-sample control.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1_din0 <= '0;
            r_s1_din1 <= '0;
            r_s1_vld  <= 1'b0;
            r_s1_en   <= 1'b0;
            r_s1_clr  <= 1'b0;
        end else if (ce) begin
            r_s1_din0 <= din0;
            r_s1_din1 <= din1;
            r_s1_vld  <= in_valid;
            r_s1_en   <= acc_en;
            r_s1_clr  <= acc_clr;
        end
    end

    // One extra bit per operand lets unsigned and signed operands share one signed multiplier.
    assign w_a_ext  = {((DIN0_SIGNED != 0) ? r_s1_din0[DIN0_WIDTH-1] : 1'b0), r_s1_din0};
    assign w_b_ext  = {((DIN1_SIGNED != 0) ? r_s1_din1[DIN1_WIDTH-1] : 1'b0), r_s1_din1};
    assign w_a_wide = PW'(w_a_ext);
    assign w_b_wide = PW'(w_b_ext);
    assign w_prod   = w_a_wide * w_b_wide;
    assign w_s2_nxt = {r_s1_vld, r_s1_en, r_s1_clr, w_prod};

    // Stage 2 registers the product; later entries are pure delay.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ND; i++) r_pipe[i] <= '0;
        end else if (ce) begin
            r_pipe[0] <= w_s2_nxt;
            for (int i = 1; i < ND; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign w_last     = r_pipe[ND-1];
    // The true product always fits in DIN0+DIN1+1 signed bits, so narrowing to ACC_WIDTH is lossless.
    assign w_prod_acc = ACC_WIDTH'(w_last.prod);
    assign w_sum      = {r_acc[ACC_WIDTH-1], r_acc} + {w_prod_acc[ACC_WIDTH-1], w_prod_acc};
    assign w_sum_ovf  = w_sum[ACC_WIDTH] ^ w_sum[ACC_WIDTH-1];
    assign w_start    = !w_last.en || w_last.clr;

    // Next accumulator, output value and sticky flag for the sample in the last stage.
    always_comb begin
        w_acc_nxt  = w_prod_acc;
        w_acc_ovf  = 1'b0;
        if (!w_start) begin
            w_acc_nxt = w_sum[ACC_WIDTH-1:0];
            w_acc_ovf = w_sum_ovf;
            if ((SAT_EN != 0) && w_sum_ovf) begin
                w_acc_nxt = w_sum[ACC_WIDTH] ? L_AMIN : L_AMAX;
            end
        end
        w_dout_nxt = w_acc_nxt[DOUT_WIDTH-1:0];
        w_dout_ovf = 1'b0;
        if (SAT_EN != 0) begin
            if (w_acc_nxt > L_DMAX) begin
                w_dout_nxt = L_DMAX[DOUT_WIDTH-1:0];
                w_dout_ovf = 1'b1;
            end else if (w_acc_nxt < L_DMIN) begin
                w_dout_nxt = L_DMIN[DOUT_WIDTH-1:0];
                w_dout_ovf = 1'b1;
            end
        end
        w_ovf_nxt = (w_start ? 1'b0 : r_ovf) | w_acc_ovf | w_dout_ovf;
    end

    // Final stage: bubbles only clear out_valid; acc, dout and ovf hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc  <= '0;
            r_dout <= '0;
            r_vld  <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (ce) begin
            r_vld <= w_last.vld;
            if (w_last.vld) begin
                r_acc  <= w_acc_nxt;
                r_dout <= w_dout_nxt;
                r_ovf  <= w_ovf_nxt;
            end
        end
    end

    assign dout      = r_dout;
    assign out_valid = r_vld;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_face_detect_mac_pipe.sv
// Bench for face_detect_mac_pipe: default instance checked every cycle against a queue model,
// plus a NUM_STAGE=6 signed-din0 instance checked with literal expectations.
module tb_face_detect_mac_pipe;

    localparam int     NS   = 4;
    localparam longint AMAX = (longint'(1) <<< 31) - 1;
    localparam longint AMIN = -(longint'(1) <<< 31);
    localparam longint DMAX = (longint'(1) <<< 23) - 1;
    localparam longint DMIN = -(longint'(1) <<< 23);

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               ce = 1'b1;
    logic               in_valid = 1'b0;
    logic [15:0]        din0 = '0;
    logic [7:0]         din1 = '0;
    logic               acc_en = 1'b0;
    logic               acc_clr = 1'b0;
    logic signed [23:0] dout;
    logic               out_valid;
    logic               ovf;

    logic               b_ce = 1'b1;
    logic               b_in_valid = 1'b0;
    logic [15:0]        b_din0 = '0;
    logic [7:0]         b_din1 = '0;
    logic               b_acc_en = 1'b0;
    logic               b_acc_clr = 1'b0;
    logic signed [23:0] b_dout;
    logic               b_out_valid;
    logic               b_ovf;

    face_detect_mac_pipe dut (
        .clk(clk), .reset(rst_n), .ce(ce), .in_valid(in_valid),
        .din0(din0), .din1(din1), .acc_en(acc_en), .acc_clr(acc_clr),
        .dout(dout), .out_valid(out_valid), .ovf(ovf)
    );

    face_detect_mac_pipe #(.NUM_STAGE(6), .DIN0_SIGNED(1), .DIN1_SIGNED(0)) dut_b (
        .clk(clk), .reset(rst_n), .ce(b_ce), .in_valid(b_in_valid),
        .din0(b_din0), .din1(b_din1), .acc_en(b_acc_en), .acc_clr(b_acc_clr),
        .dout(b_dout), .out_valid(b_out_valid), .ovf(b_ovf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int     due;
        longint d;
        bit     o;
    } exp_t;

    exp_t   q[$];
    longint exp_log[$];
    bit     ovf_log[$];
    longint m_acc = 0;
    bit     m_ovf = 1'b0;
    int     ce_count = 0;
    int     last_due = -100;
    longint e_dout = 0;
    bit     e_ovf = 1'b0;

    task automatic mdl_push();
        longint p, s, d;
        exp_t   e;
        p = longint'(din0) * longint'($signed(din1));
        if (!acc_en || acc_clr) begin
            m_acc = p;
            m_ovf = 1'b0;
        end else begin
            s = m_acc + p;
            if (s > AMAX) begin m_acc = AMAX; m_ovf = 1'b1; end
            else if (s < AMIN) begin m_acc = AMIN; m_ovf = 1'b1; end
            else m_acc = s;
        end
        d = m_acc;
        if (d > DMAX) begin d = DMAX; m_ovf = 1'b1; end
        else if (d < DMIN) begin d = DMIN; m_ovf = 1'b1; end
        e.due = ce_count + NS - 1;
        e.d   = d;
        e.o   = m_ovf;
        q.push_back(e);
        exp_log.push_back(d);
        ovf_log.push_back(m_ovf);
    endtask

    // Model update at each rising edge, comparison at each falling edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (rst_n && ce) begin
                ce_count++;
                if (in_valid) mdl_push();
            end
            @(negedge clk);
            if (!rst_n) begin
                q.delete();
                m_acc = 0;
                m_ovf = 1'b0;
                e_dout = 0;
                e_ovf = 1'b0;
                last_due = -100;
            end else if (q.size() > 0 && q[0].due == ce_count) begin
                e = q.pop_front();
                e_dout = e.d;
                e_ovf = e.o;
                last_due = ce_count;
            end
            chk("out_valid", out_valid, last_due == ce_count);
            chk("dout", $signed(dout), e_dout);
            chk("ovf", ovf, e_ovf);
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [15:0] a, input logic [7:0] b, input logic en, input logic clr);
        @(negedge clk);
        din0 = a; din1 = b; acc_en = en; acc_clr = clr; in_valid = 1'b1;
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic b_send(input logic [15:0] a, input logic [7:0] b, input logic en, input logic clr);
        @(negedge clk);
        b_din0 = a; b_din1 = b; b_acc_en = en; b_acc_clr = clr; b_in_valid = 1'b1;
    endtask

    // Instance B: output exactly 6 ce-cycles after the sample, held through bubbles.
    task automatic b_run(input longint old_v, input longint new_v);
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            if (i == 1) b_in_valid = 1'b0;
            chk("b_out_valid", b_out_valid, i == 6);
            chk("b_dout", $signed(b_dout), (i >= 6) ? new_v : old_v);
            chk("b_ovf", b_ovf, 0);
        end
    endtask

    initial begin
        int base;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_dout", $signed(dout), 0);
        chk("reset_out_valid", out_valid, 0);
        rst_n = 1'b1;

        // Product only, extreme operands.
        base = exp_log.size();
        send(16'd65535, -8'sd128, 1'b0, 1'b0);
        idle(6);
        chk("lit_prod", exp_log[base], -8388480);
        chk("lit_prod_ovf", ovf_log[base], 0);

        // Accumulate group.
        base = exp_log.size();
        send(16'd1000, 8'd100, 1'b1, 1'b1);
        send(16'd2000, -8'sd50, 1'b1, 1'b0);
        send(16'd3, 8'd7, 1'b1, 1'b0);
        idle(6);
        chk("lit_grp0", exp_log[base], 100000);
        chk("lit_grp1", exp_log[base+1], 0);
        chk("lit_grp2", exp_log[base+2], 21);

        // Saturation and sticky flag, then a clearing sample.
        base = exp_log.size();
        send(16'd65535, 8'sd127, 1'b1, 1'b1);
        send(16'd65535, 8'sd127, 1'b1, 1'b0);
        idle(6);
        send(16'd1, 8'd1, 1'b1, 1'b1);
        idle(6);
        chk("lit_sat0", exp_log[base], 8322945);
        chk("lit_sat1", exp_log[base+1], 8388607);
        chk("lit_sat1_ovf", ovf_log[base+1], 1);
        chk("lit_clr", exp_log[base+2], 1);
        chk("lit_clr_ovf", ovf_log[base+2], 0);

        // ce stall mid-stream.
        base = exp_log.size();
        send(16'd10, 8'd3, 1'b0, 1'b0);
        send(16'd20, -8'sd2, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        ce = 1'b0;
        repeat (5) @(negedge clk);
        ce = 1'b1;
        send(16'd7, 8'd7, 1'b0, 1'b0);
        send(16'd100, -8'sd1, 1'b0, 1'b0);
        idle(8);
        chk("lit_stall0", exp_log[base], 30);
        chk("lit_stall1", exp_log[base+1], -40);
        chk("lit_stall2", exp_log[base+2], 49);
        chk("lit_stall3", exp_log[base+3], -100);

        // Reset with three samples in flight.
        send(16'd9, 8'd9, 1'b1, 1'b1);
        send(16'd9, 8'd9, 1'b1, 1'b0);
        send(16'd9, 8'd9, 1'b1, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("rst_mid_dout", $signed(dout), 0);
        chk("rst_mid_out_valid", out_valid, 0);
        chk("rst_mid_ovf", ovf, 0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        idle(8);
        send(16'd5, 8'd6, 1'b1, 1'b0);
        idle(6);
        chk("lit_post_rst", exp_log[exp_log.size()-1], 30);

        // Parameter sweep instance.
        b_send(16'hFFFF, 8'd255, 1'b0, 1'b0);
        b_run(0, -255);
        b_send(16'hFFFD, 8'd10, 1'b1, 1'b0);
        b_run(-255, -285);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
